// File: rtl/pipe_reg_chain.sv
// Parametrised valid/ready pipeline register chain. Bubbles collapse while the output stalls.
// Reports occupancy and supports a synchronous squash of all stages.
module pipe_reg_chain #(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    // Handshake: a word moves across a port on a rising edge only when valid and ready
    // are both high in the cycle before; valid never depends on ready of the same port.
    logic [DEPTH-1:0] v_q, v_d;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [WIDTH-1:0] d_d [DEPTH];
    logic [DEPTH-1:0] adv;
    logic             in_xfer;
    logic [CW-1:0]    cnt;

    // A stage may advance if it is empty or anything downstream of it can advance.
    always_comb begin
        logic a;
        adv = '0;
        a   = !v_q[DEPTH-1] | out_ready;
        adv[DEPTH-1] = a;
        for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
            a      = !v_q[i] | a;
            adv[i] = a;
        end
    end

    assign in_ready  = adv[0] & !flush;
    assign in_xfer   = in_valid & in_ready;
    assign out_valid = v_q[DEPTH-1] & !flush;
    assign out_data  = d_q[DEPTH-1];

    always_comb begin
        v_d = v_q;
        for (int i = 0; i < int'(DEPTH); i++) begin
            d_d[i] = d_q[i];
        end
        if (flush) begin
            v_d = '0;
        end else begin
            if (adv[0]) begin
                v_d[0] = in_xfer;
                if (in_xfer) begin
                    d_d[0] = in_data;
                end
            end
            for (int i = 1; i < int'(DEPTH); i++) begin
                if (adv[i]) begin
                    v_d[i] = v_q[i-1];
                    if (v_q[i-1]) begin
                        d_d[i] = d_q[i-1];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                d_q[i] <= RESET_VAL;
            end
        end else begin
            v_q <= v_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                d_q[i] <= d_d[i];
            end
        end
    end

    // Occupancy reflects registered state only, so a flush shows up after its edge.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            cnt = cnt + CW'(v_q[i]);
        end
    end

    assign count = cnt;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain: directed stream/backpressure/bubble/flush/reset cases on two
// instances plus a random WIDTH x DEPTH sweep checked against a FIFO scoreboard.
module tb_pipe_reg_chain;

  logic clk;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- instance A: WIDTH=8 DEPTH=2, nonzero reset value
  logic       a_rst, a_flush, a_iv, a_ir, a_ov, a_or;
  logic [7:0] a_id, a_od;
  logic [1:0] a_cnt;
  logic [7:0] a_q[$];

  pipe_reg_chain #(.WIDTH(8), .DEPTH(2), .RESET_VAL(8'h5A)) u_a (
    .clk(clk), .rst(a_rst), .flush(a_flush),
    .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .count(a_cnt)
  );

  // ---------------- instance B: WIDTH=8 DEPTH=3
  logic       b_rst, b_flush, b_iv, b_ir, b_ov, b_or;
  logic [7:0] b_id, b_od;
  logic [1:0] b_cnt;
  logic [7:0] b_q[$];

  pipe_reg_chain #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h00)) u_b (
    .clk(clk), .rst(b_rst), .flush(b_flush),
    .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .count(b_cnt)
  );

  // Drive one cycle of inputs, then apply the transfers of the coming edge to the scoreboard.
  task automatic a_cycle(input logic iv, input logic [7:0] id, input logic ordy, input logic fl);
    @(posedge clk); #1;
    a_iv = iv; a_id = id; a_or = ordy; a_flush = fl;
    #3;
    if (fl) a_q.delete();
    else begin
      if (a_ov && a_or) begin
        if (a_q.size() == 0) check("a_unexpected_out", 1, 0);
        else check("a_order", a_od, a_q.pop_front());
      end
      if (a_iv && a_ir) a_q.push_back(a_id);
    end
  endtask

  task automatic b_cycle(input logic iv, input logic [7:0] id, input logic ordy, input logic fl);
    @(posedge clk); #1;
    b_iv = iv; b_id = id; b_or = ordy; b_flush = fl;
    #3;
    if (fl) b_q.delete();
    else begin
      if (b_ov && b_or) begin
        if (b_q.size() == 0) check("b_unexpected_out", 1, 0);
        else check("b_order", b_od, b_q.pop_front());
      end
      if (b_iv && b_ir) b_q.push_back(b_id);
    end
  endtask

  // ---------------- random sweep over WIDTH x DEPTH
  for (genvar gi = 0; gi < 9; gi++) begin : g_sw
    localparam int W  = (gi < 3) ? 1 : (gi < 6) ? 8 : 64;
    localparam int D  = (gi % 3 == 0) ? 1 : (gi % 3 == 1) ? 2 : 5;
    localparam int CW = $clog2(D + 1);

    logic          s_rst, s_flush, s_iv, s_ir, s_ov, s_or, s_drain;
    logic [W-1:0]  s_id, s_od;
    logic [CW-1:0] s_cnt;
    logic [W-1:0]  sq[$];

    pipe_reg_chain #(.WIDTH(W), .DEPTH(D)) u_sw (
      .clk(clk), .rst(s_rst), .flush(s_flush),
      .in_valid(s_iv), .in_ready(s_ir), .in_data(s_id),
      .out_valid(s_ov), .out_ready(s_or), .out_data(s_od), .count(s_cnt)
    );

    initial begin
      s_rst = 1'b1; s_flush = 1'b0; s_iv = 1'b0; s_or = 1'b0; s_id = '0; s_drain = 1'b0;
      @(posedge clk); #1 s_rst = 1'b0;
      for (int c = 0; c < 400; c++) begin
        @(posedge clk); #1;
        s_drain = (c >= 380);
        s_iv    = s_drain ? 1'b0 : ($urandom_range(0, 99) < 60);
        s_or    = s_drain ? 1'b1 : ($urandom_range(0, 99) < 55);
        s_flush = !s_drain && ($urandom_range(0, 99) < 3);
        s_id    = W'({$urandom, $urandom});
        #3;
        check($sformatf("sw%0d_count", gi), 64'(s_cnt), 64'(sq.size()));
        check($sformatf("sw%0d_in_ready", gi), 64'(s_ir),
              64'(!s_flush && ((sq.size() < D) || s_or)));
        if (sq.size() == 0) check($sformatf("sw%0d_idle_valid", gi), 64'(s_ov), 64'(0));
        if (s_flush) begin
          check($sformatf("sw%0d_flush_valid", gi), 64'(s_ov), 64'(0));
          sq.delete();
        end else begin
          if (s_ov && s_or) begin
            if (sq.size() == 0) check($sformatf("sw%0d_unexpected_out", gi), 1, 0);
            else check($sformatf("sw%0d_data", gi), 64'(s_od), 64'(sq.pop_front()));
          end
          if (s_iv && s_ir) sq.push_back(s_id);
        end
      end
      check($sformatf("sw%0d_drained", gi), 64'(sq.size()), 64'(0));
    end
  end

  // ---------------- directed sequences
  initial begin
    a_rst = 1'b1; a_flush = 1'b0; a_iv = 1'b0; a_or = 1'b0; a_id = '0;
    b_rst = 1'b1; b_flush = 1'b0; b_iv = 1'b0; b_or = 1'b0; b_id = '0;
    #3;
    check("rst_out_valid", a_ov, 0);
    check("rst_count", a_cnt, 0);
    check("rst_out_data", a_od, 8'h5A);
    check("rst_in_ready", a_ir, 1);
    @(posedge clk); #1;
    a_rst = 1'b0; b_rst = 1'b0;

    // stream A1..A3 with out_ready held high
    a_cycle(1, 8'hA1, 1, 0);
    check("lat_edge0_valid", a_ov, 0);
    a_cycle(1, 8'hA2, 1, 0);
    check("lat_edge1_valid", a_ov, 0);
    a_cycle(1, 8'hA3, 1, 0);
    check("stream_first_valid", a_ov, 1);
    check("stream_first_data", a_od, 8'hA1);
    check("stream_count0", a_cnt, 2);
    a_cycle(0, 8'h00, 1, 0);
    check("stream_second_data", a_od, 8'hA2);
    check("stream_count1", a_cnt, 2);
    a_cycle(0, 8'h00, 1, 0);
    check("stream_third_data", a_od, 8'hA3);
    a_cycle(0, 8'h00, 1, 0);
    check("stream_empty_count", a_cnt, 0);
    check("stream_sb_empty", a_q.size(), 0);

    // backpressure on a full chain
    a_cycle(1, 8'h11, 0, 0);
    a_cycle(1, 8'h22, 0, 0);
    a_cycle(1, 8'h33, 0, 0);
    check("full_in_ready", a_ir, 0);
    check("full_count", a_cnt, 2);
    check("full_out_data", a_od, 8'h11);
    a_cycle(1, 8'h33, 1, 0);
    check("full_pass_in_ready", a_ir, 1);
    check("full_pass_out_data", a_od, 8'h11);
    a_cycle(0, 8'h00, 0, 0);
    check("full_pass_count", a_cnt, 2);
    check("full_pass_out_data2", a_od, 8'h22);

    // async reset with two items in flight, between clock edges
    #2 a_rst = 1'b1;
    #1;
    check("arst_out_valid", a_ov, 0);
    check("arst_count", a_cnt, 0);
    check("arst_out_data", a_od, 8'h5A);
    a_q.delete();
    @(posedge clk); #1 a_rst = 1'b0;
    a_cycle(1, 8'hB1, 1, 0);
    check("post_rst_in_ready", a_ir, 1);
    a_cycle(0, 8'h00, 1, 0);
    check("post_rst_count", a_cnt, 1);
    a_cycle(0, 8'h00, 1, 0);
    check("post_rst_data", a_od, 8'hB1);
    a_cycle(0, 8'h00, 1, 0);
    check("post_rst_sb_empty", a_q.size(), 0);

    // bubble collapse on DEPTH=3: build v=101 with the output stalled
    b_cycle(1, 8'h40, 0, 0);
    b_cycle(0, 8'h00, 0, 0);
    b_cycle(1, 8'h41, 0, 0);
    b_cycle(1, 8'h44, 0, 0);
    check("bubble_in_ready", b_ir, 1);
    check("bubble_count_before", b_cnt, 2);
    b_cycle(0, 8'h00, 0, 0);
    check("bubble_count_after", b_cnt, 3);
    check("bubble_full_in_ready", b_ir, 0);
    check("bubble_out_data", b_od, 8'h40);
    b_cycle(0, 8'h00, 1, 0);
    b_cycle(0, 8'h00, 1, 0);
    b_cycle(0, 8'h00, 1, 0);
    b_cycle(0, 8'h00, 1, 0);
    check("bubble_drain_count", b_cnt, 0);
    check("bubble_sb_empty", b_q.size(), 0);

    // flush of a full DEPTH=3 chain while both sides want to transfer
    b_cycle(1, 8'h61, 0, 0);
    b_cycle(1, 8'h62, 0, 0);
    b_cycle(1, 8'h63, 0, 0);
    b_cycle(1, 8'h64, 1, 1);
    check("flush_count_same_cycle", b_cnt, 3);
    check("flush_in_ready", b_ir, 0);
    check("flush_out_valid", b_ov, 0);
    b_cycle(1, 8'h70, 1, 0);
    check("flush_count_after", b_cnt, 0);
    check("flush_out_valid_after", b_ov, 0);
    check("flush_reaccept", b_ir, 1);
    b_cycle(0, 8'h00, 1, 0);
    b_cycle(0, 8'h00, 1, 0);
    b_cycle(0, 8'h00, 1, 0);
    check("flush_sb_empty", b_q.size(), 0);

    while (cyc < 440) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
